// File: rtl/mdio_ctrl.sv
// Clause-22 MDIO management master: serializes single read/write commands
// into MDIO frames on mdc/mdio and returns read data on a one-cycle strobe.
module mdio_ctrl #(
  parameter int unsigned MDC_HALF = 25,
  parameter int unsigned PRE_LEN  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int unsigned DIV_W = 9;
  localparam int unsigned BIT_W = 7;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * MDC_HALF - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MDC_HALF);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PRE_LEN + 31);
  localparam logic [BIT_W-1:0] PRE_B    = BIT_W'(PRE_LEN);
  // Frame positions relative to the end of the preamble
  localparam logic [BIT_W:0]   REL_TA1  = (BIT_W + 1)'(14);
  localparam logic [BIT_W:0]   REL_TA2  = (BIT_W + 1)'(15);
  localparam logic [BIT_W:0]   REL_DATA = (BIT_W + 1)'(16);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_TAIL  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state, state_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [BIT_W-1:0] bit_q, bit_n;
  logic             wr_q, wr_n;
  logic [4:0]       phy_q, phy_n;
  logic [4:0]       reg_q, reg_n;
  logic [15:0]      wdata_q, wdata_n;
  logic [15:0]      sh_q, sh_n;
  logic             err_q, err_n;
  logic [BIT_W:0]   rel_q, rel_n;
  logic [31:0]      frame;
  logic             bit_val, oe_n, o_n, mdc_n;

  // Borrow bit (MSB) set while still inside the preamble
  assign rel_q = {1'b0, bit_q} - {1'b0, PRE_B};

  // Next-state, counters, read capture and next output values
  always_comb begin
    state_n = state;
    div_n   = div_q;
    bit_n   = bit_q;
    wr_n    = wr_q;
    phy_n   = phy_q;
    reg_n   = reg_q;
    wdata_n = wdata_q;
    sh_n    = sh_q;
    err_n   = err_q;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_n = S_SHIFT;
          div_n   = '0;
          bit_n   = '0;
          wr_n    = req_wr;
          phy_n   = req_phy;
          reg_n   = req_reg;
          wdata_n = req_wdata;
          sh_n    = '0;
          err_n   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_HALF && !wr_q) begin
          if (rel_q == REL_TA2 && mdio_i) err_n = 1'b1;
          if (!rel_q[BIT_W] && rel_q >= REL_DATA) sh_n = {sh_q[14:0], mdio_i};
        end
        if (div_q == DIV_LAST) begin
          div_n = '0;
          if (bit_q == BIT_LAST) begin
            state_n = S_TAIL;
            bit_n   = '0;
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end
      S_TAIL: begin
        if (div_q == DIV_LAST) begin
          state_n = S_RESP;
          div_n   = '0;
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    frame   = {2'b01, (wr_n ? 2'b01 : 2'b10), phy_n, reg_n, 2'b10, wdata_n};
    rel_n   = {1'b0, bit_n} - {1'b0, PRE_B};
    bit_val = rel_n[BIT_W] ? 1'b1 : frame[5'd31 - rel_n[4:0]];
    oe_n    = (state_n == S_SHIFT) && (wr_n || rel_n[BIT_W] || rel_n < REL_TA1);
    o_n     = oe_n ? bit_val : 1'b1;
    mdc_n   = (state_n == S_SHIFT || state_n == S_TAIL) && div_n >= DIV_HALF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      wr_q      <= 1'b0;
      phy_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      sh_q      <= '0;
      err_q     <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
    end else begin
      state     <= state_n;
      div_q     <= div_n;
      bit_q     <= bit_n;
      wr_q      <= wr_n;
      phy_q     <= phy_n;
      reg_q     <= reg_n;
      wdata_q   <= wdata_n;
      sh_q      <= sh_n;
      err_q     <= err_n;
      req_ready <= (state_n == S_IDLE);
      rsp_valid <= (state_n == S_RESP);
      busy      <= (state_n != S_IDLE);
      mdc       <= mdc_n;
      mdio_o    <= o_n;
      mdio_oe   <= oe_n;
      // Response fields hold until the next completion
      if (state_n == S_RESP) begin
        rsp_rdata <= wr_q ? 16'h0000 : sh_n;
        rsp_err   <= !wr_q && err_n;
      end
    end
  end

endmodule

// File: tb/tb_mdio_ctrl.sv
// Directed bench for mdio_ctrl: default-parameter instance plus a short-frame
// instance (PRE_LEN=0, MDC_HALF=2), with a small PHY model on mdio_i.
module tb_mdio_ctrl;

  logic        clk, rst, sel;
  logic        req_valid, req_wr;
  logic [4:0]  req_phy, req_reg;
  logic [15:0] req_wdata;
  logic        mdio_i;

  logic        req_ready_a, rsp_valid_a, rsp_err_a, busy_a, mdc_a, mdio_o_a, mdio_oe_a;
  logic [15:0] rsp_rdata_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, busy_b, mdc_b, mdio_o_b, mdio_oe_b;
  logic [15:0] rsp_rdata_b;

  logic        req_ready_m, rsp_valid_m, rsp_err_m, busy_m, mdc_m, mdio_o_m, mdio_oe_m;
  logic [15:0] rsp_rdata_m;

  int checks = 0;
  int failures = 0;

  mdio_ctrl dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(req_ready_a),
    .req_wr(req_wr), .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .busy(busy_a),
    .mdc(mdc_a), .mdio_o(mdio_o_a), .mdio_oe(mdio_oe_a), .mdio_i(mdio_i)
  );

  mdio_ctrl #(.MDC_HALF(2), .PRE_LEN(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(req_ready_b),
    .req_wr(req_wr), .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .busy(busy_b),
    .mdc(mdc_b), .mdio_o(mdio_o_b), .mdio_oe(mdio_oe_b), .mdio_i(mdio_i)
  );

  assign req_ready_m = sel ? req_ready_b : req_ready_a;
  assign rsp_valid_m = sel ? rsp_valid_b : rsp_valid_a;
  assign rsp_rdata_m = sel ? rsp_rdata_b : rsp_rdata_a;
  assign rsp_err_m   = sel ? rsp_err_b   : rsp_err_a;
  assign busy_m      = sel ? busy_b      : busy_a;
  assign mdc_m       = sel ? mdc_b       : mdc_a;
  assign mdio_o_m    = sel ? mdio_o_b    : mdio_o_a;
  assign mdio_oe_m   = sel ? mdio_oe_b   : mdio_oe_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PHY model: on bus release drive TA1=1, TA2=0, then data, one bit per MDC fall
  logic        phy_en;
  logic [15:0] phy_data;
  logic [17:0] phy_sh = '1;
  logic        mdc_p = 1'b0;
  logic        oe_p = 1'b0;
  always @(negedge clk) begin
    if (oe_p && !mdio_oe_m) phy_sh <= {1'b1, 1'b0, phy_data};
    else if (mdc_p && !mdc_m) phy_sh <= {phy_sh[16:0], 1'b1};
    mdc_p <= mdc_m;
    oe_p  <= mdio_oe_m;
  end
  assign mdio_i = phy_en ? phy_sh[17] : 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it to its response, recording each bit's first cycle
  task automatic run_cmd(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] wd, output logic [63:0] ob, output logic [63:0] oeb,
                         output int lat, output int mdc_bad, output int rdy_bad,
                         output logic acc, output logic [15:0] rd, output logic er);
    int hp, nb, ph;
    hp = sel ? 2 : 25;
    nb = sel ? 32 : 64;
    ob = '0; oeb = '0; lat = -1; mdc_bad = 0; rdy_bad = 0; rd = 'x; er = 1'bx;
    @(negedge clk);
    acc = req_ready_m;
    req_valid = 1'b1; req_wr = wr; req_phy = phy; req_reg = rg; req_wdata = wd;
    for (int c = 1; c <= 5000; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (rsp_valid_m) begin
        lat = c; rd = rsp_rdata_m; er = rsp_err_m;
        if (mdc_m !== 1'b0) mdc_bad++;
        break;
      end
      if (req_ready_m) rdy_bad++;
      ph = (c - 1) % (2 * hp);
      if (ph == 0 && (c - 1) / (2 * hp) < nb) begin
        ob[nb - 1 - (c - 1) / (2 * hp)]  = mdio_o_m;
        oeb[nb - 1 - (c - 1) / (2 * hp)] = mdio_oe_m;
      end
      if (mdc_m !== (ph >= hp)) mdc_bad++;
    end
  endtask

  initial begin
    logic [63:0] ob, oeb;
    int          lat, mb, rb, r, cnt;
    logic        acc, er;
    logic [15:0] rd;

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
    req_phy = '0; req_reg = '0; req_wdata = '0; phy_en = 1'b0; phy_data = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready_a), 64'd0);
    check("rst_req_ready_b", 64'(req_ready_b), 64'd0);
    check("rst_outputs", {rsp_valid_a, rsp_err_a, busy_a, mdc_a, mdio_o_a, mdio_oe_a}, 64'b000010);
    check("rst_rdata", 64'(rsp_rdata_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(req_ready_a), 64'd1);

    // Write, default parameters
    run_cmd(1'b1, 5'h01, 5'h00, 16'h1140, ob, oeb, lat, mb, rb, acc, rd, er);
    check("wr_accept", 64'(acc), 64'd1);
    check("wr_latency", 64'(lat), 64'd3251);
    check("wr_stream", ob, {32'hFFFF_FFFF, 32'h5082_1140});
    check("wr_oe", oeb, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wr_mdc_bad", 64'(mb), 64'd0);
    check("wr_ready_low", 64'(rb), 64'd0);
    check("wr_rdata", 64'(rd), 64'd0);
    check("wr_err", 64'(er), 64'd0);
    @(negedge clk);
    check("wr_rsp_one_cycle", {rsp_valid_a, busy_a, req_ready_a}, 64'b001);

    // Read with a responding PHY
    phy_en = 1'b1; phy_data = 16'h0141;
    run_cmd(1'b0, 5'h03, 5'h02, 16'h0000, ob, oeb, lat, mb, rb, acc, rd, er);
    check("rd_latency", 64'(lat), 64'd3251);
    check("rd_stream", ob, {32'hFFFF_FFFF, 32'h618B_FFFF});
    check("rd_oe", oeb, 64'hFFFF_FFFF_FFFC_0000);
    check("rd_mdc_bad", 64'(mb), 64'd0);
    check("rd_rdata", 64'(rd), 64'h0141);
    check("rd_err", 64'(er), 64'd0);
    repeat (3) @(negedge clk);
    check("rd_hold", {rsp_valid_a, rsp_err_a, rsp_rdata_a}, {2'b00, 16'h0141});

    // Read with no PHY: bus pulled high
    phy_en = 1'b0;
    run_cmd(1'b0, 5'h1F, 5'h1F, 16'h0000, ob, oeb, lat, mb, rb, acc, rd, er);
    check("nophy_latency", 64'(lat), 64'd3251);
    check("nophy_rdata", 64'(rd), 64'hFFFF);
    check("nophy_err", 64'(er), 64'd1);

    // Short frame instance
    sel = 1'b1;
    run_cmd(1'b1, 5'h12, 5'h0D, 16'hBEEF, ob, oeb, lat, mb, rb, acc, rd, er);
    check("short_accept", 64'(acc), 64'd1);
    check("short_latency", 64'(lat), 64'd133);
    check("short_stream", ob, {32'h0, 32'h5936_BEEF});
    check("short_oe", oeb, {32'h0, 32'hFFFF_FFFF});
    check("short_mdc_bad", 64'(mb), 64'd0);
    check("short_rsp", {rd, er}, 64'd0);
    sel = 1'b0;
    @(negedge clk);

    // Reset in the middle of bit 20 of a read (mdc high)
    phy_en = 1'b1; phy_data = 16'h5555;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_phy = 5'h03; req_reg = 5'h02;
    for (int c = 1; c <= 1031; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
    end
    check("pre_rst_mdc", 64'(mdc_a), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {mdc_a, mdio_oe_a, mdio_o_a, busy_a, rsp_valid_a, req_ready_a}, 64'b001000);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(req_ready_a), 64'd1);
    cnt = 0;
    for (int c = 0; c < 3400; c++) begin
      @(negedge clk);
      if (rsp_valid_a) cnt++;
    end
    check("midrst_no_rsp", 64'(cnt), 64'd0);
    run_cmd(1'b1, 5'h07, 5'h04, 16'h8000, ob, oeb, lat, mb, rb, acc, rd, er);
    check("postrst_latency", 64'(lat), 64'd3251);
    check("postrst_stream", ob, {32'hFFFF_FFFF, 32'h5392_8000});
    check("postrst_rsp", {rd, er}, 64'd0);

    // Back-to-back with req_valid held; fields change after the first accept
    phy_data = 16'hC3A5;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_phy = 5'h03; req_reg = 5'h02;
    r = -1; rb = 0;
    for (int c = 1; c <= 5000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_wr = 1'b1; req_phy = 5'h1A; req_reg = 5'h11; req_wdata = 16'h0F0F;
      end
      if (rsp_valid_a) begin
        r = c;
        break;
      end
      if (req_ready_a) rb++;
    end
    check("b2b_first_latency", 64'(r), 64'd3251);
    check("b2b_first_rsp", {rsp_err_a, rsp_rdata_a}, {1'b0, 16'hC3A5});
    check("b2b_ready_low", 64'(rb), 64'd0);
    @(negedge clk);
    check("b2b_ready_after_resp", {req_ready_a, rsp_valid_a}, 64'b10);
    @(negedge clk);
    check("b2b_second_accept", {busy_a, req_ready_a}, 64'b10);
    req_valid = 1'b0;
    r = -1; rb = 0;
    for (int c = 2; c <= 5000; c++) begin
      @(negedge clk);
      if (rsp_valid_a) begin
        r = c;
        break;
      end
      if (req_ready_a) rb++;
    end
    check("b2b_second_latency", 64'(r), 64'd3251);
    check("b2b_second_rsp", {rsp_err_a, rsp_rdata_a}, 64'd0);
    check("b2b_second_ready_low", 64'(rb), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
